serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor, the inverse companion to the combinational full-adder cell. It computes `a - b - bin` over `WIDTH` bits, processing one bit per clock LSB-first through a single full-subtractor cell and a registered borrow. It is used where area matters more than latency. It exposes a start/busy/done handshake, so a controller can launch an operation and collect the difference, borrow-out and signed overflow.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on accepted `start`.
- `b`  in  WIDTH  subtrahend; captured on accepted `start`.
- `bin`  in  1  borrow-in; captured on accepted `start`.
- `diff`  out  WIDTH  result `a - b - bin` mod 2^WIDTH; registered.
- `bout`  out  1  borrow-out; 1 iff unsigned `a < b + bin`.
- `ovf`  out  1  signed overflow of the subtraction.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when `diff`/`bout`/`ovf` update.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: processing bits.
  - DONE: one cycle, `done=1`.
- IDLE → RUN when `start=1`. On that edge:
  - load the operand shift registers with `a` and `b`;
  - load the borrow register with `bin`;
  - clear the bit counter to 0;
  - save `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow calculation.
- RUN, every edge, with `x`/`y` the current LSBs of the shift registers and `br` the borrow register:
  - result bit = `x ^ y ^ br`, shifted into the internal result register from the MSB end;
  - `br_next = (~x & y) | (~(x ^ y) & br)`;
  - shift both operand registers right by 1;
  - increment the counter.
- RUN → DONE on the edge that processes bit `WIDTH-1`. On that edge:
  - `diff` ← the completed internal result;
  - `bout` ← final borrow;
  - `ovf` ← `(a_msb != b_msb) && (diff_msb != a_msb)`.
- DONE → RUN if `start=1`; this is a back-to-back launch with fresh capture. Otherwise DONE → IDLE.
- `start` is ignored while in RUN; the operation is not restarted or extended.
- `a`, `b` and `bin` may change freely after capture without affecting the result in flight.
- `diff`, `bout` and `ovf` hold their last completed value through IDLE and the next RUN. They change only on the completion edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- The counter is `$clog2(WIDTH)` bits wide and never wraps inside an operation.

## Timing
- Reset values: `diff=0`, `bout=0`, `ovf=0`, `busy=0`, `done=0`. State is IDLE; counter, borrow and shift registers are 0.
- `rst` has priority over all inputs in every state. Reset during RUN aborts the operation:
  - no `done` pulse;
  - outputs return to their reset values on that edge.
- Let edge T be the edge at which `start` is accepted.
  - `busy=1` from after T through after T+WIDTH-1 (exactly WIDTH cycles).
  - The completion edge is T+WIDTH. After it: `busy=0`, `done=1` for one cycle, and results are valid.
- Latency from `start` sampled to `done` high is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles with continuous `start`. `start` held high in DONE relaunches at edge T+WIDTH+1.
- `busy` and `done` are never high together. Both are registered (state-decoded, no combinational path from inputs).

## Test plan
- **Reset:** assert `rst` for 2 cycles with `start=1` and random operands → all outputs 0, `busy=0`, and no `done` while `rst=1`.
- **Basic subtraction:** `WIDTH=8`, `a=100`, `b=58`, `bin=0`, pulse `start` → `busy` high exactly 8 cycles, then `done` 1 cycle, `diff=8'd42`, `bout=0`, `ovf=0`.
- **Borrow out:** `a=5`, `b=7`, `bin=0` → `diff=8'hFE`, `bout=1`, `ovf=0`.
- **Signed overflow:**
  - `a=8'h80`, `b=8'h01`, `bin=0` → `diff=8'h7F`, `bout=0`, `ovf=1`.
  - `a=0`, `b=0`, `bin=1` → `diff=8'hFF`, `bout=1`, `ovf=0`.
- **Handshake and operand stability:**
  - Hold `start` high through RUN and change `a`/`b` each cycle → the first result is unaffected.
  - A relaunch occurs at the cycle after `done`; the second result matches the operands present at that DONE cycle.
- **Abort:** assert `rst` at bit 4 of an operation whose previous result was `diff=8'd42` → outputs become 0 immediately and no `done` follows. A subsequent `a=200`, `b=1` gives `diff=8'd199`, `bout=0`, `ovf=0`.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake bundle for the bit-serial subtractor
// master drives start/a/b/bin and observes diff/bout/ovf/busy/done; slave is the reverse
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;
    modport master (output start, a, b, bin, input diff, bout, ovf, busy, done);
    modport slave (input start, a, b, bin, output diff, bout, ovf, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one bit per clock LSB-first, registered borrow
// clk, rst (sync, active high); s.start/a/b/bin in, s.diff/bout/ovf/busy/done out
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] sa, sb, res, res_n, diff;
    logic [CW-1:0] cnt;
    logic br, br_n, amsb, bmsb, bout, ovf, x, y, r, last;
    always_comb begin
        x = sa[0];
        y = sb[0];
        r = x ^ y ^ br;
        br_n = (~x & y) | (~(x ^ y) & br);
        res_n = {r, res[WIDTH-1:1]};
        last = cnt == CW'(WIDTH - 1);
        nxt = state == RUN ? (last ? DONE : RUN) : (s.start ? RUN : IDLE);
    end
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sa <= '0;
            sb <= '0;
            res <= '0;
            cnt <= '0;
            br <= 1'b0;
            amsb <= 1'b0;
            bmsb <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf <= 1'b0;
        end else if (state != RUN && s.start) begin
            sa <= s.a;
            sb <= s.b;
            br <= s.bin;
            cnt <= '0;
            amsb <= s.a[WIDTH-1];
            bmsb <= s.b[WIDTH-1];
        end else if (state == RUN) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            br <= br_n;
            res <= res_n;
            cnt <= last ? cnt : cnt + CW'(1);
            if (last) begin
                diff <= res_n;
                bout <= br_n;
                // operands of opposite sign overflow when the result sign departs from a
                ovf <= (amsb != bmsb) && (r != amsb);
            end
        end
    end
    assign s.diff = diff;
    assign s.bout = bout;
    assign s.ovf = ovf;
    assign s.busy = state == RUN;
    assign s.done = state == DONE;
endmodule
